// File: rtl/btb_update_scheduler.sv
// btb_update_scheduler
// Purpose: sequences every write into the single-write-port BTB array. Branch
// resolution updates are queued in a small FIFO and drained whenever the array
// is free; a flush request replaces the queue with a full-array invalidation
// walk, one block per accepted write.
// Ports:
//   CLK, RST                      clock, synchronous active-high reset
//   update_valid/ready            resolution update handshake
//   update_PC/ASID/target         resolved branch PC, its ASID and target
//   flush_req                     one-cycle request to invalidate the whole BTB
//   flush_busy                    invalidation walk in progress
//   flush_done                    one-cycle pulse after the final flush write
//   btb_wr_valid/ready            write handshake towards the array
//   btb_wr_index/entry/all        write address; all=1 writes every way
//   btb_wr_vld_bit/tag/target     write payload

// Tag hash: XOR-fold of the PC bits above the index field, seeded with the ASID.
module btb_tag_hash #(
    parameter int unsigned BTB_INDEX_WIDTH                = 4,
    parameter int unsigned BTB_TAG_WIDTH                  = 8,
    parameter int unsigned LOG_BTB_NWAY_ENTRIES_PER_BLOCK = 2,
    parameter int unsigned ASID_WIDTH                     = 4
) (
    input  logic [31:0]              pc,
    input  logic [ASID_WIDTH-1:0]    asid,
    output logic [BTB_TAG_WIDTH-1:0] tag
);
    localparam int unsigned SHIFT  = BTB_INDEX_WIDTH + LOG_BTB_NWAY_ENTRIES_PER_BLOCK + 1;
    localparam int unsigned NCHUNK = (32 - SHIFT + BTB_TAG_WIDTH - 1) / BTB_TAG_WIDTH;
    localparam int unsigned HI_W   = NCHUNK * BTB_TAG_WIDTH;

    logic [HI_W-1:0] hi;

    always_comb begin
        hi  = HI_W'(pc >> SHIFT);
        tag = BTB_TAG_WIDTH'(asid);
        for (int i = 0; i < int'(NCHUNK); i++) begin
            tag = tag ^ hi[i*BTB_TAG_WIDTH +: BTB_TAG_WIDTH];
        end
    end
endmodule

module btb_update_scheduler #(
    parameter int unsigned UPDATE_QUEUE_DEPTH             = 4,
    parameter int unsigned TARGET_WIDTH                   = 32,
    parameter int unsigned BTB_INDEX_WIDTH                = 4,
    parameter int unsigned BTB_TAG_WIDTH                  = 8,
    parameter int unsigned LOG_BTB_NWAY_ENTRIES_PER_BLOCK = 2,
    parameter int unsigned ASID_WIDTH                     = 4
) (
    input  logic                                      CLK,
    input  logic                                      RST,
    input  logic                                      update_valid,
    output logic                                      update_ready,
    input  logic [31:0]                               update_PC,
    input  logic [ASID_WIDTH-1:0]                     update_ASID,
    input  logic [TARGET_WIDTH-1:0]                   update_target,
    input  logic                                      flush_req,
    output logic                                      flush_busy,
    output logic                                      flush_done,
    output logic                                      btb_wr_valid,
    input  logic                                      btb_wr_ready,
    output logic [BTB_INDEX_WIDTH-1:0]                btb_wr_index,
    output logic [LOG_BTB_NWAY_ENTRIES_PER_BLOCK-1:0] btb_wr_entry,
    output logic                                      btb_wr_all,
    output logic                                      btb_wr_vld_bit,
    output logic [BTB_TAG_WIDTH-1:0]                  btb_wr_tag,
    output logic [TARGET_WIDTH-1:0]                   btb_wr_target
);
    localparam int unsigned IDX_W = BTB_INDEX_WIDTH;
    localparam int unsigned ENT_W = LOG_BTB_NWAY_ENTRIES_PER_BLOCK;
    localparam int unsigned PTR_W = (UPDATE_QUEUE_DEPTH > 1) ? $clog2(UPDATE_QUEUE_DEPTH) : 1;
    localparam int unsigned CNT_W = PTR_W + 1;
    localparam logic [IDX_W-1:0] LAST_INDEX = '1;

    typedef enum logic {
        ST_READY = 1'b0,
        ST_FLUSH = 1'b1
    } state_t;

    typedef struct packed {
        logic [IDX_W-1:0]         index;
        logic [ENT_W-1:0]         entry;
        logic [BTB_TAG_WIDTH-1:0] tag;
        logic [TARGET_WIDTH-1:0]  target;
    } upd_t;

    state_t           state, state_nx;
    upd_t             mem [UPDATE_QUEUE_DEPTH];
    upd_t             new_upd;
    upd_t             head;
    logic [PTR_W-1:0] rd_ptr, rd_ptr_nx, wr_ptr, wr_ptr_nx;
    logic [CNT_W-1:0] count, count_nx;
    logic [IDX_W-1:0] flush_cnt, flush_cnt_nx;
    logic             flush_done_nx;
    logic [BTB_TAG_WIDTH-1:0] new_tag;
    logic             full, empty, enq, deq;

    btb_tag_hash #(
        .BTB_INDEX_WIDTH                (BTB_INDEX_WIDTH),
        .BTB_TAG_WIDTH                  (BTB_TAG_WIDTH),
        .LOG_BTB_NWAY_ENTRIES_PER_BLOCK (LOG_BTB_NWAY_ENTRIES_PER_BLOCK),
        .ASID_WIDTH                     (ASID_WIDTH)
    ) u_tag_hash (
        .pc   (update_PC),
        .asid (update_ASID),
        .tag  (new_tag)
    );

    // Array fields are derived once, at enqueue time.
    always_comb begin
        new_upd.index  = update_PC[IDX_W+ENT_W:ENT_W+1];
        new_upd.entry  = update_PC[ENT_W:1];
        new_upd.tag    = new_tag;
        new_upd.target = update_target;
    end

    assign full  = (count == CNT_W'(UPDATE_QUEUE_DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    // Depends only on registered state and the flush request, never on btb_wr_ready.
    assign update_ready = !RST && (state == ST_READY) && !full && !flush_req;
    assign flush_busy   = (state == ST_FLUSH);
    assign enq          = update_valid && update_ready;
    assign deq          = (state == ST_READY) && btb_wr_valid && btb_wr_ready;

    // Write port: FIFO head in READY, invalidation of one block per write in FLUSH.
    always_comb begin
        btb_wr_valid   = 1'b0;
        btb_wr_index   = '0;
        btb_wr_entry   = '0;
        btb_wr_all     = 1'b0;
        btb_wr_vld_bit = 1'b0;
        btb_wr_tag     = '0;
        btb_wr_target  = '0;
        case (state)
            ST_READY: begin
                if (!empty) begin
                    btb_wr_valid   = 1'b1;
                    btb_wr_index   = head.index;
                    btb_wr_entry   = head.entry;
                    btb_wr_vld_bit = 1'b1;
                    btb_wr_tag     = head.tag;
                    btb_wr_target  = head.target;
                end
            end
            ST_FLUSH: begin
                btb_wr_valid = 1'b1;
                btb_wr_index = flush_cnt;
                btb_wr_all   = 1'b1;
            end
            default: ;
        endcase
    end

    // Next state, queue bookkeeping and walk counter.
    always_comb begin
        state_nx      = state;
        rd_ptr_nx     = rd_ptr;
        wr_ptr_nx     = wr_ptr;
        count_nx      = count;
        flush_cnt_nx  = flush_cnt;
        flush_done_nx = 1'b0;
        case (state)
            ST_READY: begin
                if (flush_req) begin
                    // Queued updates predate the flush and are dropped.
                    state_nx     = ST_FLUSH;
                    rd_ptr_nx    = '0;
                    wr_ptr_nx    = '0;
                    count_nx     = '0;
                    flush_cnt_nx = '0;
                end else begin
                    if (enq) wr_ptr_nx = wr_ptr + PTR_W'(1);
                    if (deq) rd_ptr_nx = rd_ptr + PTR_W'(1);
                    count_nx = count + CNT_W'(enq) - CNT_W'(deq);
                end
            end
            ST_FLUSH: begin
                if (flush_req) begin
                    flush_cnt_nx = '0;
                end else if (btb_wr_ready) begin
                    if (flush_cnt == LAST_INDEX) begin
                        state_nx      = ST_READY;
                        flush_cnt_nx  = '0;
                        flush_done_nx = 1'b1;
                    end else begin
                        flush_cnt_nx = flush_cnt + IDX_W'(1);
                    end
                end
            end
            default: state_nx = ST_READY;
        endcase
    end

    // State register.
    always_ff @(posedge CLK) begin
        if (RST) begin
            state      <= ST_READY;
            rd_ptr     <= '0;
            wr_ptr     <= '0;
            count      <= '0;
            flush_cnt  <= '0;
            flush_done <= 1'b0;
        end else begin
            state      <= state_nx;
            rd_ptr     <= rd_ptr_nx;
            wr_ptr     <= wr_ptr_nx;
            count      <= count_nx;
            flush_cnt  <= flush_cnt_nx;
            flush_done <= flush_done_nx;
        end
    end

    // Queue storage; contents are only observed through a non-empty head.
    always_ff @(posedge CLK) begin
        if (enq) mem[wr_ptr] <= new_upd;
    end
endmodule

// File: tb/tb_btb_update_scheduler.sv
// tb_btb_update_scheduler
// Purpose: self-checking bench for btb_update_scheduler. A queue-based model of
// the scheduler predicts every output each cycle; directed scenarios plus a
// randomized phase drive it, with literal expectations pinning key values.
module tb_btb_update_scheduler;
    localparam int unsigned DEPTH = 4;
    localparam int unsigned TGTW  = 32;
    localparam int unsigned IDXW  = 4;
    localparam int unsigned TAGW  = 8;
    localparam int unsigned LOGW  = 2;
    localparam int unsigned ASIDW = 4;
    localparam int NSETS = 1 << IDXW;

    logic              CLK;
    logic              RST;
    logic              update_valid;
    logic              update_ready;
    logic [31:0]       update_PC;
    logic [ASIDW-1:0]  update_ASID;
    logic [TGTW-1:0]   update_target;
    logic              flush_req;
    logic              flush_busy;
    logic              flush_done;
    logic              btb_wr_valid;
    logic              btb_wr_ready;
    logic [IDXW-1:0]   btb_wr_index;
    logic [LOGW-1:0]   btb_wr_entry;
    logic              btb_wr_all;
    logic              btb_wr_vld_bit;
    logic [TAGW-1:0]   btb_wr_tag;
    logic [TGTW-1:0]   btb_wr_target;

    btb_update_scheduler #(
        .UPDATE_QUEUE_DEPTH             (DEPTH),
        .TARGET_WIDTH                   (TGTW),
        .BTB_INDEX_WIDTH                (IDXW),
        .BTB_TAG_WIDTH                  (TAGW),
        .LOG_BTB_NWAY_ENTRIES_PER_BLOCK (LOGW),
        .ASID_WIDTH                     (ASIDW)
    ) dut (
        .CLK            (CLK),
        .RST            (RST),
        .update_valid   (update_valid),
        .update_ready   (update_ready),
        .update_PC      (update_PC),
        .update_ASID    (update_ASID),
        .update_target  (update_target),
        .flush_req      (flush_req),
        .flush_busy     (flush_busy),
        .flush_done     (flush_done),
        .btb_wr_valid   (btb_wr_valid),
        .btb_wr_ready   (btb_wr_ready),
        .btb_wr_index   (btb_wr_index),
        .btb_wr_entry   (btb_wr_entry),
        .btb_wr_all     (btb_wr_all),
        .btb_wr_vld_bit (btb_wr_vld_bit),
        .btb_wr_tag     (btb_wr_tag),
        .btb_wr_target  (btb_wr_target)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    typedef struct packed {
        bit [IDXW-1:0] index;
        bit [LOGW-1:0] entry;
        bit [TAGW-1:0] tag;
        bit [TGTW-1:0] target;
    } ent_t;

    // Model state: pending updates, walk flag/position, pending done pulse.
    ent_t q[$];
    bit   m_flush;
    int   m_fidx;
    bit   m_done;

    int errors;
    int checks;
    int n_fwr;
    int n_uwr;
    int n_done;
    bit s_ready;

    function automatic bit [TAGW-1:0] hash_model(input bit [31:0] pc, input bit [ASIDW-1:0] asid);
        bit [31:0]     rest = pc >> (IDXW + LOGW + 1);
        bit [TAGW-1:0] t    = TAGW'(asid);
        while (rest != 0) begin
            t    = t ^ rest[TAGW-1:0];
            rest = rest >> TAGW;
        end
        return t;
    endfunction

    function automatic ent_t make_entry(input bit [31:0] pc, input bit [ASIDW-1:0] asid,
                                        input bit [31:0] tgt);
        ent_t e;
        e.entry  = LOGW'((pc >> 1) % (32'd1 << LOGW));
        e.index  = IDXW'((pc >> (LOGW + 1)) % (32'd1 << IDXW));
        e.tag    = hash_model(pc, asid);
        e.target = tgt;
        return e;
    endfunction

    task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", nm, act, exp, $time);
        end
    endtask

    // One clock cycle: drive, compare every output with the model, clock, advance model.
    task automatic cyc(input bit uv, input bit [31:0] pc, input bit [ASIDW-1:0] asid,
                       input bit [31:0] tgt, input bit fr, input bit wr, input bit rst);
        bit   e_ready;
        bit   nd;
        ent_t h;
        update_valid  = uv;
        update_PC     = pc;
        update_ASID   = asid;
        update_target = tgt;
        flush_req     = fr;
        btb_wr_ready  = wr;
        RST           = rst;
        #1;
        e_ready = !rst && !m_flush && (q.size() < int'(DEPTH)) && !fr;
        check("update_ready", 64'(update_ready), 64'(e_ready));
        check("flush_busy", 64'(flush_busy), 64'(m_flush));
        check("flush_done", 64'(flush_done), 64'(m_done));
        check("wr_valid", 64'(btb_wr_valid), 64'(m_flush || q.size() > 0));
        if (m_flush) begin
            check("flush_index", 64'(btb_wr_index), 64'(m_fidx));
            check("flush_all", 64'(btb_wr_all), 64'd1);
            check("flush_vld_bit", 64'(btb_wr_vld_bit), 64'd0);
            check("flush_data", {btb_wr_entry, btb_wr_tag, btb_wr_target}, 64'd0);
        end else if (q.size() > 0) begin
            h = q[0];
            check("upd_index", 64'(btb_wr_index), 64'(h.index));
            check("upd_entry", 64'(btb_wr_entry), 64'(h.entry));
            check("upd_tag", 64'(btb_wr_tag), 64'(h.tag));
            check("upd_target", 64'(btb_wr_target), 64'(h.target));
            check("upd_all", 64'(btb_wr_all), 64'd0);
            check("upd_vld_bit", 64'(btb_wr_vld_bit), 64'd1);
        end
        s_ready = update_ready;
        if (!rst && btb_wr_valid && wr) begin
            if (btb_wr_all) n_fwr++;
            else n_uwr++;
        end
        if (flush_done) n_done++;
        @(posedge CLK);
        nd = 1'b0;
        if (rst) begin
            q.delete();
            m_flush = 1'b0;
            m_fidx  = 0;
        end else if (m_flush) begin
            if (fr) m_fidx = 0;
            else if (wr) begin
                if (m_fidx == NSETS - 1) begin
                    m_flush = 1'b0;
                    m_fidx  = 0;
                    nd      = 1'b1;
                end else begin
                    m_fidx++;
                end
            end
        end else if (fr) begin
            q.delete();
            m_flush = 1'b1;
            m_fidx  = 0;
        end else begin
            if (q.size() > 0 && wr) void'(q.pop_front());
            if (e_ready && uv) q.push_back(make_entry(pc, asid, tgt));
        end
        m_done = nd;
        #1;
    endtask

    task automatic idle(input bit wr);
        cyc(1'b0, 32'd0, '0, 32'd0, 1'b0, wr, 1'b0);
    endtask

    task automatic rnd_upd(input bit wr);
        cyc(1'b1, $urandom, ASIDW'($urandom), $urandom, 1'b0, wr, 1'b0);
    endtask

    task automatic pulse_flush(input bit wr);
        cyc(1'b0, 32'd0, '0, 32'd0, 1'b1, wr, 1'b0);
    endtask

    initial begin
        int k;
        errors = 0; checks = 0;
        n_fwr = 0; n_uwr = 0; n_done = 0; s_ready = 1'b0;
        m_flush = 1'b0; m_fidx = 0; m_done = 1'b0;
        update_valid = 1'b0; update_PC = '0; update_ASID = '0; update_target = '0;
        flush_req = 1'b0; btb_wr_ready = 1'b1; RST = 1'b1;
        repeat (2) @(posedge CLK);
        #1;

        // Reset state
        cyc(1'b0, 32'd0, '0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("reset_data", {btb_wr_index, btb_wr_entry, btb_wr_tag, btb_wr_target}, 64'd0);
        idle(1'b1);
        check("ready_after_reset", 64'(s_ready), 64'd1);

        // Single update with hand-derived fields
        cyc(1'b1, 32'h0000_1234, 4'd3, 32'hDEAD_BEEF, 1'b0, 1'b1, 1'b0);
        check("t1_valid", 64'(btb_wr_valid), 64'd1);
        check("t1_index", 64'(btb_wr_index), 64'd6);
        check("t1_entry", 64'(btb_wr_entry), 64'd2);
        check("t1_tag", 64'(btb_wr_tag), 64'h27);
        check("t1_target", 64'(btb_wr_target), 64'hDEAD_BEEF);
        check("t1_vld_bit", 64'(btb_wr_vld_bit), 64'd1);
        idle(1'b1);
        idle(1'b1);

        // Five back-to-back updates against a stalled array
        for (int i = 0; i < 5; i++) rnd_upd(1'b0);
        check("t2_fifth_ready", 64'(s_ready), 64'd0);
        n_uwr = 0;
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("t2_drain_writes", 64'(n_uwr), 64'd4);

        // Steady enqueue+dequeue at occupancy 2 across pointer wrap
        rnd_upd(1'b0);
        rnd_upd(1'b0);
        for (int i = 0; i < 10; i++) begin
            rnd_upd(1'b1);
            check("t3_ready", 64'(s_ready), 64'd1);
        end
        n_uwr = 0;
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t3_drain_writes", 64'(n_uwr), 64'd2);

        // Flush with three queued updates, array ready toggled randomly
        for (int i = 0; i < 3; i++) rnd_upd(1'b0);
        n_fwr = 0; n_done = 0;
        pulse_flush(1'b0);
        k = 0;
        while (n_done == 0 && k < 300) begin
            idle(1'($urandom_range(0, 1)));
            k++;
        end
        check("t4_done_seen", 64'(n_done), 64'd1);
        check("t4_flush_writes", 64'(n_fwr), 64'(NSETS));
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t4_single_done", 64'(n_done), 64'd1);

        // Flush re-requested at index 5
        n_fwr = 0; n_done = 0;
        pulse_flush(1'b1);
        for (int i = 0; i < 5; i++) idle(1'b1);
        check("t5_index_before_restart", 64'(btb_wr_index), 64'd5);
        pulse_flush(1'b1);
        check("t5_index_after_restart", 64'(btb_wr_index), 64'd0);
        k = 0;
        while (n_done == 0 && k < 100) begin
            idle(1'b1);
            k++;
        end
        for (int i = 0; i < 3; i++) idle(1'b1);
        check("t5_flush_writes", 64'(n_fwr), 64'(6 + NSETS));
        check("t5_done_count", 64'(n_done), 64'd1);

        // Reset in the middle of a walk
        n_done = 0;
        pulse_flush(1'b1);
        for (int i = 0; i < 7; i++) idle(1'b1);
        check("t6_index", 64'(btb_wr_index), 64'd7);
        cyc(1'b0, 32'd0, '0, 32'd0, 1'b0, 1'b1, 1'b1);
        check("t6_valid", 64'(btb_wr_valid), 64'd0);
        check("t6_busy", 64'(flush_busy), 64'd0);
        idle(1'b1);
        check("t6_ready", 64'(s_ready), 64'd1);
        for (int i = 0; i < 20; i++) idle(1'b1);
        check("t6_no_done", 64'(n_done), 64'd0);

        // Randomized traffic with occasional flushes and resets
        for (int i = 0; i < 2000; i++) begin
            cyc(1'($urandom_range(0, 1)), $urandom, ASIDW'($urandom), $urandom,
                ($urandom_range(0, 59) == 0), ($urandom_range(0, 3) != 0),
                ($urandom_range(0, 399) == 0));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        errors++;
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $fatal(1, "timeout");
    end
endmodule
